// File: rtl/cache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// cache_refill_ctrl
//   Miss-handling sequencer for the data cache. On a miss it writes a dirty
//   victim line back to main memory one word at a time, then refills the
//   missing line one word at a time and pulses done_o so the cache can
//   install the new tag. It owns the main-memory port and also produces the
//   pipeline stall term and the writeback/refill statistics counters.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   miss_req_i          cache needs service (held until done_o is seen)
//   victim_dirty_i      victim line is dirty (sampled at miss start)
//   victim_addr_i       byte address inside the victim line (sampled at start)
//   fill_addr_i         byte address inside the missing line (sampled at start)
//   line_rd_idx_o       victim word index into the cache array (combinational)
//   line_rd_data_i      victim word at line_rd_idx_o, same cycle
//   line_wr_en_o        write one refill word into the cache line
//   line_wr_idx_o       refill word index
//   line_wr_data_o      refill word
//   mem_rd_req_o        main-memory read request
//   mem_wr_req_o        main-memory write request
//   mem_addr_o          word-aligned memory address
//   mem_wr_data_o       memory write data
//   mem_rd_data_i       memory read data, valid while mem_gnt_i=1
//   mem_gnt_i           one-cycle completion strobe for the current word
//   busy_o              sequencer is not idle
//   done_o              one-cycle pulse: line refilled
//   stall_o             miss_req_i | busy_o
//   wb_cnt_o            completed writebacks (wraps)
//   fill_cnt_o          completed refills (wraps)
// ---------------------------------------------------------------------------
module cache_refill_ctrl #(
  parameter int LINE_ADDR_LEN = 2,
  parameter int CNT_W         = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     miss_req_i,
  input  logic                     victim_dirty_i,
  input  logic [31:0]              victim_addr_i,
  input  logic [31:0]              fill_addr_i,
  output logic [LINE_ADDR_LEN-1:0] line_rd_idx_o,
  input  logic [31:0]              line_rd_data_i,
  output logic                     line_wr_en_o,
  output logic [LINE_ADDR_LEN-1:0] line_wr_idx_o,
  output logic [31:0]              line_wr_data_o,
  output logic                     mem_rd_req_o,
  output logic                     mem_wr_req_o,
  output logic [31:0]              mem_addr_o,
  output logic [31:0]              mem_wr_data_o,
  input  logic [31:0]              mem_rd_data_i,
  input  logic                     mem_gnt_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     stall_o,
  output logic [CNT_W-1:0]         wb_cnt_o,
  output logic [CNT_W-1:0]         fill_cnt_o
);

  localparam int BASE_W = 32 - LINE_ADDR_LEN - 2;
  localparam logic [LINE_ADDR_LEN-1:0] LAST_WORD = '1;
  localparam logic [LINE_ADDR_LEN-1:0] WORD_ONE  = LINE_ADDR_LEN'(1);
  localparam logic [CNT_W-1:0]         CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [LINE_ADDR_LEN-1:0] word_cnt_q, word_cnt_d;
  logic [BASE_W-1:0]        victim_base_q, victim_base_d;
  logic [BASE_W-1:0]        fill_base_q, fill_base_d;
  logic [CNT_W-1:0]         wb_cnt_q, wb_cnt_d;
  logic [CNT_W-1:0]         fill_cnt_q, fill_cnt_d;

  // State, word counter, latched line bases and statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      word_cnt_q    <= '0;
      victim_base_q <= '0;
      fill_base_q   <= '0;
      wb_cnt_q      <= '0;
      fill_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      word_cnt_q    <= word_cnt_d;
      victim_base_q <= victim_base_d;
      fill_base_q   <= fill_base_d;
      wb_cnt_q      <= wb_cnt_d;
      fill_cnt_q    <= fill_cnt_d;
    end
  end

  // Next-state logic and memory/cache-array handshake outputs.
  always_comb begin
    state_d        = state_q;
    word_cnt_d     = word_cnt_q;
    victim_base_d  = victim_base_q;
    fill_base_d    = fill_base_q;
    wb_cnt_d       = wb_cnt_q;
    fill_cnt_d     = fill_cnt_q;
    line_rd_idx_o  = word_cnt_q;
    line_wr_en_o   = 1'b0;
    line_wr_idx_o  = '0;
    line_wr_data_o = 32'd0;
    mem_rd_req_o   = 1'b0;
    mem_wr_req_o   = 1'b0;
    mem_addr_o     = 32'd0;
    mem_wr_data_o  = 32'd0;
    done_o         = 1'b0;

    case (state_q)
      IDLE: begin
        // mem_gnt_i is deliberately ignored here: nothing is outstanding.
        if (miss_req_i) begin
          victim_base_d = victim_addr_i[31:LINE_ADDR_LEN+2];
          fill_base_d   = fill_addr_i[31:LINE_ADDR_LEN+2];
          word_cnt_d    = '0;
          state_d       = victim_dirty_i ? WB : FILL;
        end else begin
          state_d = IDLE;
        end
      end
      WB: begin
        mem_wr_req_o  = 1'b1;
        mem_addr_o    = {victim_base_q, word_cnt_q, 2'b00};
        mem_wr_data_o = line_rd_data_i;
        if (mem_gnt_i) begin
          // Incrementing past the last word wraps to 0, ready for the refill.
          word_cnt_d = word_cnt_q + WORD_ONE;
          if (word_cnt_q == LAST_WORD) begin
            state_d  = FILL;
            wb_cnt_d = wb_cnt_q + CNT_ONE;
          end else begin
            state_d = WB;
          end
        end else begin
          state_d = WB;
        end
      end
      FILL: begin
        mem_rd_req_o = 1'b1;
        mem_addr_o   = {fill_base_q, word_cnt_q, 2'b00};
        if (mem_gnt_i) begin
          line_wr_en_o   = 1'b1;
          line_wr_idx_o  = word_cnt_q;
          line_wr_data_o = mem_rd_data_i;
          word_cnt_d     = word_cnt_q + WORD_ONE;
          if (word_cnt_q == LAST_WORD) begin
            state_d    = DONE;
            fill_cnt_d = fill_cnt_q + CNT_ONE;
          end else begin
            state_d = FILL;
          end
        end else begin
          state_d = FILL;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o     = (state_q != IDLE);
  assign stall_o    = miss_req_i | busy_o;
  assign wb_cnt_o   = wb_cnt_q;
  assign fill_cnt_o = fill_cnt_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cache_refill_ctrl
//   Self-checking bench for cache_refill_ctrl. A miss is described by its
//   victim/fill addresses and dirty flag; the bench derives the list of
//   memory words that must be written back and refilled, the data each must
//   carry, the cycle on which done must appear and the counter values, and
//   compares the DUT against that description cycle by cycle while playing
//   the role of the memory (random wait states) and the cache array.
// ---------------------------------------------------------------------------
module tb_cache_refill_ctrl;

  localparam int LA  = 2;
  localparam int NW  = 1 << LA;
  localparam int CW  = 32;
  localparam int MAX_CYC = 200;

  logic          clk = 1'b0;
  logic          rst;
  logic          miss_req_i, victim_dirty_i;
  logic [31:0]   victim_addr_i, fill_addr_i;
  logic [LA-1:0] line_rd_idx_o;
  logic [31:0]   line_rd_data_i;
  logic          line_wr_en_o;
  logic [LA-1:0] line_wr_idx_o;
  logic [31:0]   line_wr_data_o;
  logic          mem_rd_req_o, mem_wr_req_o;
  logic [31:0]   mem_addr_o, mem_wr_data_o, mem_rd_data_i;
  logic          mem_gnt_i;
  logic          busy_o, done_o, stall_o;
  logic [CW-1:0] wb_cnt_o, fill_cnt_o;

  logic [31:0]   vline [NW];
  logic [31:0]   mem_salt;
  int            checks = 0;
  int            errors = 0;
  int            exp_wb = 0;
  int            exp_fill = 0;

  always #5 clk = ~clk;

  cache_refill_ctrl #(.LINE_ADDR_LEN(LA), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .miss_req_i     (miss_req_i),
    .victim_dirty_i (victim_dirty_i),
    .victim_addr_i  (victim_addr_i),
    .fill_addr_i    (fill_addr_i),
    .line_rd_idx_o  (line_rd_idx_o),
    .line_rd_data_i (line_rd_data_i),
    .line_wr_en_o   (line_wr_en_o),
    .line_wr_idx_o  (line_wr_idx_o),
    .line_wr_data_o (line_wr_data_o),
    .mem_rd_req_o   (mem_rd_req_o),
    .mem_wr_req_o   (mem_wr_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wr_data_o  (mem_wr_data_o),
    .mem_rd_data_i  (mem_rd_data_i),
    .mem_gnt_i      (mem_gnt_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .stall_o        (stall_o),
    .wb_cnt_o       (wb_cnt_o),
    .fill_cnt_o     (fill_cnt_o)
  );

  // Cache array model: victim word by index. Memory model: word i of any
  // line holds mem_salt + i.
  assign line_rd_data_i = vline[line_rd_idx_o];
  assign mem_rd_data_i  = mem_salt + {{(32-LA){1'b0}}, mem_addr_o[LA+1:2]};

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Several idle cycles with random mem_gnt pulses that must be ignored.
  task automatic idle_spur(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      miss_req_i = 1'b0;
      mem_gnt_i  = 1'($urandom_range(1, 0));
      #1;
      check_eq("idle_busy", 32'(busy_o), 32'd0);
      check_eq("idle_wen", 32'(line_wr_en_o), 32'd0);
      check_eq("idle_done", 32'(done_o), 32'd0);
      check_eq("idle_req", 32'({mem_rd_req_o, mem_wr_req_o}), 32'd0);
      check_eq("idle_wbcnt", wb_cnt_o, 32'(exp_wb));
      check_eq("idle_fillcnt", fill_cnt_o, 32'(exp_fill));
    end
    @(negedge clk);
    mem_gnt_i = 1'b0;
  endtask

  // One complete miss. minw/maxw bound the memory wait per word; hold keeps
  // miss_req high through DONE; mutate changes the miss inputs mid-fill;
  // abort_n>0 resets the DUT after that many fill grants; spur_done pulses
  // mem_gnt during the DONE cycle.
  task automatic run_miss(input bit dirty, input logic [31:0] va, input logic [31:0] fa,
                          input int minw, input int maxw, input bit hold, input bit mutate,
                          input int abort_n, input bit spur_done);
    int k_wb, k_fl, cyc, exp_cyc, w, wcnt;
    bit is_wb;
    logic [31:0] exp_a;
    @(negedge clk);
    for (int i = 0; i < NW; i++) vline[i] = $urandom;
    miss_req_i     = 1'b1;
    victim_dirty_i = dirty;
    victim_addr_i  = va;
    fill_addr_i    = fa;
    mem_gnt_i      = 1'b0;
    #1;
    check_eq("start_busy", 32'(busy_o), 32'd0);
    check_eq("start_stall", 32'(stall_o), 32'd1);
    check_eq("start_req", 32'({mem_rd_req_o, mem_wr_req_o}), 32'd0);
    k_wb = 0; k_fl = 0; cyc = 1; exp_cyc = 1; wcnt = 0;
    w = $urandom_range(maxw, minw);
    while (k_fl < NW && cyc < MAX_CYC) begin
      @(negedge clk);
      if (abort_n > 0 && k_fl == abort_n) begin
        miss_req_i = 1'b0;
        mem_gnt_i  = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_rdreq", 32'(mem_rd_req_o), 32'd0);
        check_eq("rst_done", 32'(done_o), 32'd0);
        check_eq("rst_wbcnt", wb_cnt_o, 32'd0);
        check_eq("rst_fillcnt", fill_cnt_o, 32'd0);
        exp_wb = 0;
        exp_fill = 0;
        return;
      end
      is_wb = dirty && (k_wb < NW);
      exp_a = is_wb ? {va[31:LA+2], LA'(k_wb), 2'b00} : {fa[31:LA+2], LA'(k_fl), 2'b00};
      mem_gnt_i = (wcnt == w);
      #1;
      check_eq("req_kind", 32'({mem_wr_req_o, mem_rd_req_o}), is_wb ? 32'd2 : 32'd1);
      check_eq("mem_addr", mem_addr_o, exp_a);
      check_eq("busy", 32'(busy_o), 32'd1);
      check_eq("done_early", 32'(done_o), 32'd0);
      if (is_wb) begin
        check_eq("wb_data", mem_wr_data_o, vline[k_wb]);
        check_eq("wb_wen", 32'(line_wr_en_o), 32'd0);
      end else if (mem_gnt_i) begin
        check_eq("fill_wen", 32'(line_wr_en_o), 32'd1);
        check_eq("fill_idx", 32'(line_wr_idx_o), 32'(k_fl));
        check_eq("fill_data", line_wr_data_o, mem_salt + 32'(k_fl));
      end else begin
        check_eq("wait_wen", 32'(line_wr_en_o), 32'd0);
      end
      cyc++;
      if (mem_gnt_i) begin
        exp_cyc += w + 1;
        if (is_wb) k_wb++;
        else k_fl++;
        wcnt = 0;
        w = $urandom_range(maxw, minw);
        if (mutate && !is_wb && k_fl == 1) begin
          fill_addr_i    = $urandom;
          victim_addr_i  = $urandom;
          victim_dirty_i = 1'b1;
        end
      end else begin
        wcnt++;
      end
    end
    check_eq("timeout", 32'(cyc < MAX_CYC), 32'd1);
    @(negedge clk);
    mem_gnt_i = spur_done;
    #1;
    if (dirty) exp_wb++;
    exp_fill++;
    check_eq("done", 32'(done_o), 32'd1);
    check_eq("done_latency", 32'(cyc), 32'(exp_cyc));
    check_eq("done_busy", 32'(busy_o), 32'd1);
    check_eq("done_stall", 32'(stall_o), 32'd1);
    check_eq("done_req", 32'({mem_rd_req_o, mem_wr_req_o}), 32'd0);
    check_eq("done_wen", 32'(line_wr_en_o), 32'd0);
    check_eq("wb_cnt", wb_cnt_o, 32'(exp_wb));
    check_eq("fill_cnt", fill_cnt_o, 32'(exp_fill));
    if (!hold) miss_req_i = 1'b0;
    @(posedge clk);
    #1;
    mem_gnt_i = 1'b0;
    check_eq("post_done", 32'(done_o), 32'd0);
    check_eq("post_busy", 32'(busy_o), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    miss_req_i = 1'b0;
    victim_dirty_i = 1'b0;
    victim_addr_i = 32'd0;
    fill_addr_i = 32'd0;
    mem_gnt_i = 1'b0;
    mem_salt = 32'd0;
    for (int i = 0; i < NW; i++) vline[i] = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("reset_busy", 32'(busy_o), 32'd0);
    check_eq("reset_done", 32'(done_o), 32'd0);
    check_eq("reset_stall", 32'(stall_o), 32'd0);
    check_eq("reset_wbcnt", wb_cnt_o, 32'd0);
    check_eq("reset_fillcnt", fill_cnt_o, 32'd0);

    // Clean miss, zero-wait memory returning 0xA0+i.
    mem_salt = 32'h0000_00A0;
    run_miss(1'b0, 32'd0, 32'h0000_0134, 0, 0, 1'b0, 1'b0, 0, 1'b0);

    // Dirty miss with three wait cycles per word.
    mem_salt = $urandom;
    run_miss(1'b1, 32'h0000_0200, 32'h0000_0410, 3, 3, 1'b0, 1'b0, 0, 1'b0);

    // Spurious grants in IDLE and DONE.
    idle_spur(6);
    run_miss(1'b1, $urandom, $urandom, 0, 2, 1'b0, 1'b0, 0, 1'b1);
    idle_spur(3);

    // Reset after the second fill grant, then a fresh miss.
    mem_salt = $urandom;
    run_miss(1'b0, $urandom, $urandom, 0, 1, 1'b0, 1'b0, 2, 1'b0);
    run_miss(1'b0, $urandom, $urandom, 0, 1, 1'b0, 1'b0, 0, 1'b0);

    // Back-to-back misses with miss_req held through DONE.
    run_miss(1'b1, $urandom, $urandom, 0, 1, 1'b1, 1'b0, 0, 1'b0);
    run_miss(1'b0, $urandom, $urandom, 0, 1, 1'b0, 1'b0, 0, 1'b0);

    // Miss inputs changed mid-fill must not matter.
    run_miss(1'b0, $urandom, $urandom, 0, 2, 1'b0, 1'b1, 0, 1'b0);

    // Random traffic.
    for (int t = 0; t < 24; t++) begin
      mem_salt = $urandom;
      run_miss(1'($urandom_range(1, 0)), $urandom, $urandom, 0, 3,
               ($urandom_range(3, 0) == 0), 1'($urandom_range(1, 0)), 0,
               1'($urandom_range(1, 0)));
    end
    idle_spur(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
